inv_haar_lift: RTL and testbench

- Inverse of the forward Haar lifting stage. Takes one coefficient pair per transfer: a sum word and a sign-magnitude difference word. Rebuilds the original pixel pair (im11, im21).
- Sits on the reconstruction path after coefficient storage/decoding. Feeds the image write-back logic.
- Two-stage valid/ready pipeline with backpressure, a reconstructed-pair counter and an optional parity check.

---
 rtl/inv_haar_lift_if.sv | 42 ++++
 rtl/inv_haar_lift.sv | 180 ++++++++++++++++++
 tb/tb_inv_haar_lift.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_haar_lift_if.sv
// ============================================================================
// Module      : inv_haar_lift_if
// Description : Handshake and data bundle for the inverse Haar lifting stage.
//               Carries the upstream coefficient transfer (start/in_ready),
//               the downstream pixel transfer (data_occur/out_ready), the
//               delivered-pair counter and the parity flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface inv_haar_lift_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);

  logic             start;
  logic             in_ready;
  logic [WIDTH-1:0] dxy_detail;
  logic [WIDTH-1:0] dxy_approx;
  logic             out_ready;
  logic             data_occur;
  logic [WIDTH-1:0] im11;
  logic [WIDTH-1:0] im21;
  logic [CNT_W-1:0] pair_count;
  logic             parity_err;

  // Environment side: supplies coefficient pairs and downstream readiness.
  modport master (
    output start, dxy_detail, dxy_approx, out_ready,
    input  in_ready, data_occur, im11, im21, pair_count, parity_err
  );

  // Block side: consumes coefficient pairs and produces pixel pairs.
  modport slave (
    input  start, dxy_detail, dxy_approx, out_ready,
    output in_ready, data_occur, im11, im21, pair_count, parity_err
  );

endinterface

`default_nettype wire

// File: rtl/inv_haar_lift.sv
// ============================================================================
// Module      : inv_haar_lift
// Description : Inverse Haar lifting stage. Each transfer carries a sum word S
//               and a sign-magnitude difference word D; the block rebuilds the
//               pixel pair im11 = (S+D)/2, im21 = (S-D)/2 through a two-stage
//               valid/ready pipeline with backpressure and counts delivered
//               pairs.
//               Optional macro INV_HAAR_PARITY_CHK_EN builds the parity check
//               (parity_err = low bit of S+D); without it parity_err is 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module inv_haar_lift #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  wire logic       clk,
  input  wire logic       reset,   // asynchronous, active-low
  inv_haar_lift_if.slave  bus
);

  // Sum/difference working width: one bit for the signed difference range,
  // one more so S+Ds and S-Ds never overflow.
  localparam int PW = WIDTH + 2;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic             ready_en;     // low until the first clock after reset
  logic             s1_valid;
  logic [WIDTH-1:0] s1_p_half;    // P[WIDTH:1]
  logic [WIDTH-1:0] s1_m_half;    // M[WIDTH:1]
  logic             s2_valid;
  logic [WIDTH-1:0] s2_im11;
  logic [WIDTH-1:0] s2_im21;
  logic [CNT_W-1:0] count;

  logic             rdy;
  logic             accept;
  logic             deliver;
  logic             s2_load;
  logic             s1_adv;

  logic             d_sign;
  logic [WIDTH-2:0] d_mag;
  logic [WIDTH:0]   ds;
  logic [PW-1:0]    ds_ext;
  logic [PW-1:0]    s_ext;
  logic [PW-1:0]    p_next;
  logic [PW-1:0]    m_next;
  logic             unused_bits;

  // --------------------------------------------------------------------------
  // Handshake control
  // --------------------------------------------------------------------------
  // Stage 2 refills when empty or when its pair leaves this cycle; stage 1
  // drains into it at the same time, which is what frees room for a new pair.
  always_comb begin
    deliver = s2_valid && bus.out_ready;
    s2_load = !s2_valid || bus.out_ready;
    s1_adv  = s2_load;
    rdy     = ready_en && (!s1_valid || s1_adv);
    accept  = bus.start && rdy;
  end

  // in_ready stays low through reset and rises on the first clock after it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1 datapath
  // --------------------------------------------------------------------------
  // Sign-magnitude to two's complement, then the full-width sum/difference.
  // Negative zero needs no special case: 0 - 0 is already 0.
  always_comb begin
    d_sign = bus.dxy_approx[WIDTH-1];
    d_mag  = bus.dxy_approx[WIDTH-2:0];
    ds     = d_sign ? ({(WIDTH+1){1'b0}} - {2'b00, d_mag}) : {2'b00, d_mag};
    ds_ext = {ds[WIDTH], ds};
    s_ext  = {2'b00, bus.dxy_detail};
    p_next = s_ext + ds_ext;
    m_next = s_ext - ds_ext;
  end

  // Bits that never reach an output: the top guard bit of both results and
  // the low bit of M (the low bit of P feeds only the optional parity path).
  assign unused_bits = &{1'b0, p_next[PW-1], p_next[0], m_next[PW-1], m_next[0]};

  // Stage 1 register: captures the halved results on accept, empties when
  // its pair moves into stage 2 with nothing new arriving.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_p_half <= '0;
      s1_m_half <= '0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_p_half <= p_next[WIDTH:1];
      s1_m_half <= m_next[WIDTH:1];
    end else if (s1_adv) begin
      s1_valid  <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 (output register)
  // --------------------------------------------------------------------------
  // Output register: holds steady while stalled, otherwise takes stage 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_im11  <= '0;
      s2_im21  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_im11 <= s1_p_half;
        s2_im21 <= s1_m_half;
      end
    end
  end

  // Delivered-pair counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (deliver) begin
      count <= count + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Optional parity check: a legal pair always gives an even P.
  // --------------------------------------------------------------------------
`ifdef INV_HAAR_PARITY_CHK_EN
  logic s1_par;
  logic s2_par;

  // Parity bit travels with the pair through stage 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_par <= 1'b0;
    end else if (accept) begin
      s1_par <= p_next[0];
    end
  end

  // Parity bit loads into the output register alongside the pixels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_par <= 1'b0;
    end else if (s2_load && s1_valid) begin
      s2_par <= s1_par;
    end
  end

  assign bus.parity_err = s2_par;
`else
  assign bus.parity_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready   = rdy;
  assign bus.data_occur = s2_valid;
  assign bus.im11       = s2_im11;
  assign bus.im21       = s2_im21;
  assign bus.pair_count = count;

endmodule

`default_nettype wire

// File: tb/tb_inv_haar_lift.sv
// ============================================================================
// Module      : tb_inv_haar_lift
// Description : Directed, self-checking bench for inv_haar_lift. A queue-based
//               arithmetic model predicts every delivered pixel pair; literal
//               expectations pin latency, backpressure and reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_inv_haar_lift;

  localparam int W  = 16;
  localparam int CW = 16;
`ifdef INV_HAAR_PARITY_CHK_EN
  localparam logic EXP_PAR_ODD = 1'b1;
`else
  localparam logic EXP_PAR_ODD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inv_haar_lift_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  inv_haar_lift #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         p;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  int   dcount = 0;
  logic armed;
  logic par_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Reconstruction straight from the arithmetic definition.
  function automatic exp_t model(input logic [W-1:0] s, input logic [W-1:0] d);
    exp_t r;
    int mag = int'(d[W-2:0]);
    int ds  = d[W-1] ? -mag : mag;
    int p   = int'(s) + ds;
    int m   = int'(s) - ds;
    r.a = W'(p >>> 1);
    r.b = W'(m >>> 1);
`ifdef INV_HAAR_PARITY_CHK_EN
    r.p = p[0];
`else
    r.p = 1'b0;
`endif
    return r;
  endfunction

  // Ready may only rise on the first clock after reset is released.
  always @(posedge clk or negedge reset) begin
    if (!reset) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // Compare process: every falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      dcount = 0;
      check("rst_data_occur", {31'd0, bus.data_occur}, 32'd0);
      check("rst_pair_count", {16'd0, bus.pair_count}, 32'd0);
      check("rst_in_ready",   {31'd0, bus.in_ready},   32'd0);
    end else begin
      check("in_ready", {31'd0, bus.in_ready},
            {31'd0, armed && (q.size() < 2 || bus.out_ready)});
      check("pair_count", {16'd0, bus.pair_count}, {16'd0, 16'(dcount)});
      if (bus.data_occur) begin
        if (q.size() == 0) begin
          check("spurious_data_occur", {31'd0, bus.data_occur}, 32'd0);
        end else begin
          check("im11",       {16'd0, bus.im11},       {16'd0, q[0].a});
          check("im21",       {16'd0, bus.im21},       {16'd0, q[0].b});
          check("parity_err", {31'd0, bus.parity_err}, {31'd0, q[0].p});
          if (bus.out_ready) begin
            void'(q.pop_front());
            dcount++;
          end
        end
      end
      if (bus.start && bus.in_ready) q.push_back(model(bus.dxy_detail, bus.dxy_approx));
    end
  end

  // Offer one pair until accepted (bounded); returns just after the accept edge.
  task automatic send(input logic [W-1:0] s, input logic [W-1:0] d);
    int   n   = 0;
    logic acc = 1'b0;
    bus.start      = 1'b1;
    bus.dxy_detail = s;
    bus.dxy_approx = d;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.start = 1'b0;
    check("send_accepted", {31'd0, acc}, 32'd1);
  endtask

  // Wait (bounded) for an output and pin its values to literals.
  task automatic wait_out(input string name, input logic [W-1:0] e11,
                          input logic [W-1:0] e21, output logic par);
    int n = 0;
    @(negedge clk);
    while (!bus.data_occur && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, {31'd0, bus.data_occur}, 32'd1);
    check({name, "_im11"},  {16'd0, bus.im11},       {16'd0, e11});
    check({name, "_im21"},  {16'd0, bus.im21},       {16'd0, e21});
    par = bus.parity_err;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.dxy_detail = '0;
    bus.dxy_approx = '0;
    bus.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_im11",   {16'd0, bus.im11},       32'd0);
    check("rst_parity", {31'd0, bus.parity_err}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 1: positive difference, latency and count
    bus.out_ready = 1'b1;
    send(16'd140, 16'h003C);
    @(negedge clk);
    check("t1_not_yet", {31'd0, bus.data_occur}, 32'd0);
    @(negedge clk);
    check("t1_valid", {31'd0, bus.data_occur}, 32'd1);
    check("t1_im11",  {16'd0, bus.im11}, 32'd100);
    check("t1_im21",  {16'd0, bus.im21}, 32'd40);
    @(negedge clk);
    check("t1_one_cycle", {31'd0, bus.data_occur}, 32'd0);
    check("t1_count",     {16'd0, bus.pair_count}, 32'd1);
    @(posedge clk);
    #1;

    // 2: negative difference, equal pixels, negative zero
    send(16'd140, 16'h803C); wait_out("t2_neg",   16'd40,  16'd100, par_seen);
    send(16'd200, 16'h0000); wait_out("t2_eq",    16'd100, 16'd100, par_seen);
    send(16'd200, 16'h8000); wait_out("t2_negz",  16'd100, 16'd100, par_seen);

    // 3: four back-to-back pairs, including truncation cases
    send(16'd1000,  16'h0064);
    send(16'd0,     16'h8005);
    send(16'hFFFF,  16'h7FFF);
    send(16'h8000,  16'h0001);
    drain("t3");
    check("t3_count", {16'd0, bus.pair_count}, 32'd8);

    // 4: backpressure, two buffered, third refused, then all delivered
    bus.out_ready = 1'b0;
    send(16'd50,  16'h000A);
    send(16'd300, 16'h8064);
    bus.start      = 1'b1;
    bus.dxy_detail = 16'd1000;
    bus.dxy_approx = 16'h0000;
    repeat (3) begin
      @(negedge clk);
      check("t4_blocked",   {31'd0, bus.in_ready},   32'd0);
      check("t4_held_v",    {31'd0, bus.data_occur}, 32'd1);
      check("t4_held_im11", {16'd0, bus.im11},       32'd30);
      check("t4_held_im21", {16'd0, bus.im21},       32'd20);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(16'd1000, 16'h0000);
    drain("t4");
    check("t4_count", {16'd0, bus.pair_count}, 32'd11);

    // 5: odd P flags parity when the check is built
    send(16'd141, 16'h003C);
    wait_out("t5", 16'd100, 16'd40, par_seen);
    check("t5_parity", {31'd0, par_seen}, {31'd0, EXP_PAR_ODD});

    // 6: reset with two pairs buffered
    bus.out_ready = 1'b0;
    send(16'd20, 16'h0002);
    send(16'd30, 16'h0004);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("t6_data_occur", {31'd0, bus.data_occur}, 32'd0);
    check("t6_pair_count", {16'd0, bus.pair_count}, 32'd0);
    check("t6_in_ready",   {31'd0, bus.in_ready},   32'd0);
    check("t6_im11",       {16'd0, bus.im11},       32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    send(16'd10, 16'h8002);
    wait_out("t6_after", 16'd4, 16'd6, par_seen);
    @(negedge clk);
    check("t6_count", {16'd0, bus.pair_count}, 32'd1);
    check("final_queue", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
